// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display arbiter
package disp_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;
  typedef logic [15:0] disp_word_t;
  localparam logic [3:0] DP_OFF = 4'b1111;
endpackage

// File: rtl/disp_hold_timer.sv
// disp_hold_timer: loadable saturating down-counter with zero flag
module disp_hold_timer #(
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic zero
);
  localparam int W = $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(HOLD_CYCLES - 1);
  logic [W-1:0] hold_cnt;
  // reload on grant, otherwise count down and stick at zero
  always_ff @(posedge clk)
    if (reset) hold_cnt <= '0;
    else if (load) hold_cnt <= LOAD;
    else if (hold_cnt != '0) hold_cnt <= hold_cnt - W'(1);
  assign zero = hold_cnt == '0;
endmodule

// File: rtl/disp_share_arb.sv
// disp_share_arb: round-robin display sharing with minimum hold; DISP_SHARE_ARB_OWNER_DP_EN shows owner on dp
module disp_share_arb
  import disp_pkg::*;
#(
  parameter int         HOLD_CYCLES = 25_000_000,
  parameter disp_word_t IDLE_WORD   = 16'h0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  disp_word_t data0,
  input  logic       req1,
  input  disp_word_t data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_in
);
  arb_state_t state, nxt;
  logic last, nlast, load, zero;
  disp_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(clk), .reset(reset), .load(load), .zero(zero)
  );
  // next grant: tie goes to the client that did not own last; owner yields on release or expired hold
  always_comb begin
    nxt = state;
    nlast = last;
    load = 1'b0;
    case (state)
      ARB_IDLE: begin
        nxt = (req0 && (!req1 || last)) ? ARB_OWN0 : req1 ? ARB_OWN1 : ARB_IDLE;
        load = req0 || req1;
      end
      ARB_OWN0:
        if (!req0 || (zero && req1)) begin
          nxt = req1 ? ARB_OWN1 : ARB_IDLE;
          nlast = 1'b0;
          load = req1;
        end
      ARB_OWN1:
        if (!req1 || (zero && req0)) begin
          nxt = req0 ? ARB_OWN0 : ARB_IDLE;
          nlast = 1'b1;
          load = req0;
        end
      default: nxt = ARB_IDLE;
    endcase
  end
  // state, grants and display registers; display follows the owner as of this edge
  always_ff @(posedge clk)
    if (reset) begin
      state <= ARB_IDLE;
      last <= 1'b1;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      {hex3, hex2, hex1, hex0} <= IDLE_WORD;
      dp_in <= DP_OFF;
    end else begin
      state <= nxt;
      last <= nlast;
      gnt0 <= nxt == ARB_OWN0;
      gnt1 <= nxt == ARB_OWN1;
      {hex3, hex2, hex1, hex0} <= state == ARB_OWN0 ? data0 : state == ARB_OWN1 ? data1 : IDLE_WORD;
`ifdef DISP_SHARE_ARB_OWNER_DP_EN
      dp_in <= state == ARB_OWN0 ? 4'b1110 : state == ARB_OWN1 ? 4'b0111 : DP_OFF;
`else
      dp_in <= DP_OFF;
`endif
    end
endmodule

// File: tb/tb_disp_share_arb.sv
// tb_disp_share_arb: directed checks of the display arbiter with HOLD_CYCLES=4
module tb_disp_share_arb;
  logic clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [15:0] data0 = 16'h0000, data1 = 16'h0000;
  logic gnt0, gnt1;
  logic [3:0] hex3, hex2, hex1, hex0, dp_in;
  int compared = 0, mismatched = 0;
  logic [8:0] g0_pat;
`ifdef DISP_SHARE_ARB_OWNER_DP_EN
  localparam logic [3:0] DP1 = 4'b0111;
`else
  localparam logic [3:0] DP1 = 4'b1111;
`endif
  disp_share_arb #(.HOLD_CYCLES(4), .IDLE_WORD(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_in(dp_in)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    check(tag, {14'd0, gnt1, gnt0}, {14'd0, g1, g0});
  endtask
  initial begin
    @(negedge clk);
    step(2);
    chk_gnt("reset_gnt", 0, 0);
    check("reset_hex", {hex3, hex2, hex1, hex0}, 16'hFFFF);
    check("reset_dp", {12'd0, dp_in}, 16'h000F);
    reset = 1'b0;
    req0 = 1'b1;
    data0 = 16'h3325;
    step(1);
    chk_gnt("single_gnt0", 1, 0);
    check("single_hex_lag", {hex3, hex2, hex1, hex0}, 16'hFFFF);
    step(1);
    check("single_hex", {hex3, hex2, hex1, hex0}, 16'h3325);
    reset = 1'b1;
    step(1);
    chk_gnt("reset2_gnt", 0, 0);
    reset = 1'b0;
    req1 = 1'b1;
    data1 = 16'h5008;
    g0_pat = 9'b1_0000_1111;
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk_gnt($sformatf("alt_step%0d", i + 1), g0_pat[i], !g0_pat[i]);
      if (i == 4) check("alt_hex_old", {hex3, hex2, hex1, hex0}, 16'h3325);
      if (i == 5) check("alt_hex_new", {hex3, hex2, hex1, hex0}, 16'h5008);
      if (i == 6) check("alt_dp_own1", {12'd0, dp_in}, {12'd0, DP1});
    end
    step(1);
    req0 = 1'b0;
    step(1);
    chk_gnt("early_release", 0, 1);
    check("early_release_hex", {hex3, hex2, hex1, hex0}, 16'h3325);
    data1 = 16'h0378;
    step(1);
    check("live_hex_a", {hex3, hex2, hex1, hex0}, 16'h0378);
    data1 = 16'h0388;
    check("live_hex_hold", {hex3, hex2, hex1, hex0}, 16'h0378);
    step(1);
    check("live_hex_b", {hex3, hex2, hex1, hex0}, 16'h0388);
    step(6);
    chk_gnt("stay_own1", 0, 1);
    req1 = 1'b0;
    step(1);
    chk_gnt("to_idle", 0, 0);
    check("to_idle_hex_lag", {hex3, hex2, hex1, hex0}, 16'h0388);
    step(1);
    check("idle_hex", {hex3, hex2, hex1, hex0}, 16'hFFFF);
    check("idle_dp", {12'd0, dp_in}, 16'h000F);
    req1 = 1'b1;
    step(3);
    chk_gnt("own1_again", 0, 1);
    reset = 1'b1;
    step(1);
    chk_gnt("midgrant_reset_gnt", 0, 0);
    check("midgrant_reset_hex", {hex3, hex2, hex1, hex0}, 16'hFFFF);
    check("midgrant_reset_dp", {12'd0, dp_in}, 16'h000F);
    reset = 1'b0;
    step(1);
    chk_gnt("after_reset_gnt1", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/disp_share_arb.md
Name: disp_share_arb

Overview:
- Arbitrates the single 4-digit seven-segment display between two cipher clients, e.g. an encrypt unit and a decrypt unit.
- Each client presents a 16-bit word of four hex nibbles and a request.
- Grants one client at a time, round-robin, with a minimum hold time so the display stays readable.
- Drives registered digit and dp nibbles straight into disp_hex_mux.

Parameters:
- HOLD_CYCLES, 25_000_000, minimum clk cycles a grant is held before the other client may take over (must be >= 1).
- IDLE_WORD, 16'h0000, nibbles shown when no client is granted.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req0  input  1  client 0 display request (level)
- data0  input  16  client 0 word; [15:12]=digit3 ... [3:0]=digit0
- req1  input  1  client 1 display request (level)
- data1  input  16  client 1 word, same packing
- gnt0  output  1  client 0 owns display
- gnt1  output  1  client 1 owns display
- hex3, hex2, hex1, hex0  output  4 each  digit nibbles to display mux
- dp_in  output  4  decimal points, active-low (4'b1111 = all off)

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; sampled only on the rising edge of clk.
- States: IDLE, OWN0, OWN1. Internal registers: hold counter hold_cnt, width $clog2(HOLD_CYCLES+1); last-owner flag last.
- Reset values: state=IDLE, gnt0=gnt1=0, hex3..hex0=IDLE_WORD nibbles, dp_in=4'b1111, hold_cnt=0, last=1 (so client 0 wins the first tie).
- IDLE:
  - Only req0 -> OWN0. Only req1 -> OWN1.
  - Both -> grant the client that is not last.
  - On entering OWNx, hold_cnt loads HOLD_CYCLES-1.
- OWNx, owner drops req:
  - Release on the next edge, regardless of hold_cnt.
  - Go to OWN(other) if the other client requests, else IDLE. last=x.
- OWNx, owner keeps req: hold_cnt decrements to 0 and saturates.
  - hold_cnt==0 and other requests -> OWN(other); reload hold_cnt; last=x.
  - hold_cnt==0 and other not requesting -> stay in OWNx indefinitely.
- Handoff goes directly OWN0<->OWN1 with no IDLE cycle. gnt0 and gnt1 are never both 1.
- gnt0/gnt1 are registered and decode the state.
- Data path:
  - Each cycle, hex3..hex0 register the owner's live data (from the state at the current edge).
  - First owner digits therefore appear one cycle after gnt rises.
  - In IDLE they register IDLE_WORD.
  - No latching of data at grant time; the owner may update its word while granted.
- reset asserted mid-grant: next edge returns all outputs to reset values, whatever hold_cnt holds.
- HOLD_CYCLES=1: a switch is possible on every cycle after grant, i.e. strict alternation when both request.

Optional Feature:
- DISP_SHARE_ARB_OWNER_DP_EN defined: dp_in indicates the owner.
  - OWN0 -> 4'b1110 (digit0 dp lit).
  - OWN1 -> 4'b0111 (digit3 dp lit).
  - IDLE -> 4'b1111.
  - Registered alongside the hex outputs.
- Undefined: dp_in is constant 4'b1111 after reset.

Decomposition:
- Shared package disp_pkg:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t.
  - typedef logic [15:0] disp_word_t.
  - localparam DP_OFF = 4'b1111.
- One natural sub-module: disp_hold_timer, the loadable saturating down-counter with a zero flag, parameterised by HOLD_CYCLES.

Test Plan (bench overrides HOLD_CYCLES=4, IDLE_WORD=16'hFFFF):
- Reset held 2 cycles -> gnt0=gnt1=0, hex3..0=F,F,F,F, dp_in=4'b1111.
- req0=1, data0=16'h3325 -> gnt0=1 after 1 edge; hex3..0=3,3,2,5 one edge later.
- req0=req1=1 from IDLE after reset -> gnt0 first. Holds 4 cycles, then gnt1 with data1=16'h5008 displayed. Alternates every 4 cycles.
- Owner 0 drops req0 at hold_cnt=2 while req1=1 -> gnt1 on the next edge, no IDLE cycle. Hold not honoured for a released owner.
- req1 only, data1 changes 16'h0378 -> 16'h0388 mid-grant -> hex outputs follow one cycle after the change.
- reset pulsed during OWN1 -> next edge IDLE, all outputs at reset values. With DISP_SHARE_ARB_OWNER_DP_EN: dp_in=4'b1110 in OWN0, 4'b0111 in OWN1.
